// File: rtl/vector_lane_scheduler.sv
// vector_lane_scheduler
//
// Purpose:
//   Walks one V-element vector operation through a bank of LANES external
//   combinational lane ALUs, one chunk of LANES elements per cycle, and
//   assembles the lane results into a full result vector. Scalar operations
//   (op_type 00 or 11) skip the lanes entirely and finish with a
//   single-cycle done pulse.
//
// Ports:
//   CLK, RST        rising-edge clock, asynchronous active-high reset
//   start_i         operation request, only looked at in IDLE
//   flush_i         synchronous abort, returns to IDLE without a done pulse
//   op_type_i       00 scalar, 01 vector-vector, 10 vector-scalar, 11 scalar
//   vec_a_i/vec_b_i operand vectors, element e at bits [e*L +: L]
//   scalar_i        broadcast operand for vector-scalar
//   lane_a_o/b_o    per-lane operands, lane j at bits [j*L +: L]
//   lane_valid_o    lane j carries a real element this cycle
//   lane_result_i   lane ALU results, combinational from lane_a_o/lane_b_o
//   chunk_o         chunk currently presented to the lanes
//   result_o        assembled result vector, held until overwritten
//   busy_o          operation accepted and not yet finished
//   done_o          one-cycle completion pulse
module vector_lane_scheduler #(
  parameter int L = 8,
  parameter int V = 20,
  parameter int LANES = 4,
  localparam int NCH = (V + LANES - 1) / LANES,
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               start_i,
  input  logic               flush_i,
  input  logic [1:0]         op_type_i,
  input  logic [V*L-1:0]     vec_a_i,
  input  logic [V*L-1:0]     vec_b_i,
  input  logic [L-1:0]       scalar_i,
  output logic [LANES*L-1:0] lane_a_o,
  output logic [LANES*L-1:0] lane_b_o,
  output logic [LANES-1:0]   lane_valid_o,
  input  logic [LANES*L-1:0] lane_result_i,
  output logic [CW-1:0]      chunk_o,
  output logic [V*L-1:0]     result_o,
  output logic               busy_o,
  output logic               done_o
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    chunk_q, chunk_d;
  logic [V*L-1:0]   a_q, b_q;
  logic [L-1:0]     scalar_q;
  logic [1:0]       op_q;
  logic [V*L-1:0]   result_q, result_d;
  logic             accept;
  logic             is_vector_op;

  // A request is taken only from IDLE, and flush always wins over start.
  assign accept       = (state_q == IDLE) && start_i && !flush_i;
  assign is_vector_op = (op_type_i == 2'b01) || (op_type_i == 2'b10);

  // State and chunk counter register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      chunk_q <= '0;
    end else begin
      state_q <= state_d;
      chunk_q <= chunk_d;
    end
  end

  // Next-state logic plus the status outputs. The chunk counter is parked
  // at zero whenever the FSM leaves RUN so the next operation starts clean.
  always_comb begin
    state_d = state_q;
    chunk_d = chunk_q;
    busy_o  = (state_q != IDLE);
    done_o  = (state_q == DONE);
    if (flush_i) begin
      state_d = IDLE;
      chunk_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            chunk_d = '0;
            state_d = is_vector_op ? RUN : DONE;
          end
        end
        RUN: begin
          if (chunk_q == CW'(NCH - 1)) begin
            state_d = DONE;
            chunk_d = '0;
          end else begin
            chunk_d = chunk_q + CW'(1);
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          chunk_d = '0;
        end
      endcase
    end
  end

  // Operand capture on acceptance; the lanes only ever see these copies,
  // so the requester may change its inputs once the op is accepted.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      a_q      <= '0;
      b_q      <= '0;
      scalar_q <= '0;
      op_q     <= 2'b00;
    end else if (accept) begin
      a_q      <= vec_a_i;
      b_q      <= vec_b_i;
      scalar_q <= scalar_i;
      op_q     <= op_type_i;
    end
  end

  // Lane operand mux. Lanes past the end of the vector in the final chunk
  // are idle and driven to zero. Kept apart from the result merge so the
  // external lane ALUs do not close a combinational loop through one block.
  always_comb begin
    int e;
    e            = 0;
    lane_a_o     = '0;
    lane_b_o     = '0;
    lane_valid_o = '0;
    if (state_q == RUN) begin
      for (int j = 0; j < LANES; j++) begin
        e = int'(chunk_q) * LANES + j;
        if (e < V) begin
          lane_valid_o[j]     = 1'b1;
          lane_a_o[j*L +: L]  = a_q[e*L +: L];
          lane_b_o[j*L +: L]  = (op_q == 2'b10) ? scalar_q : b_q[e*L +: L];
        end
      end
    end
  end

  // Merge the current chunk's lane results into the result vector. Only
  // valid lanes write, so elements outside the chunk keep their old value.
  always_comb begin
    int e;
    e        = 0;
    result_d = result_q;
    if (state_q == RUN) begin
      for (int j = 0; j < LANES; j++) begin
        e = int'(chunk_q) * LANES + j;
        if (e < V) begin
          result_d[e*L +: L] = lane_result_i[j*L +: L];
        end
      end
    end
  end

  // Result register. A flush in the middle of a chunk still keeps that
  // chunk's results; the abort only stops further chunks.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      result_q <= '0;
    end else begin
      result_q <= result_d;
    end
  end

  assign result_o = result_q;
  assign chunk_o  = (state_q == RUN) ? chunk_q : '0;

endmodule

// File: tb/tb_vector_lane_scheduler.sv
// tb_vector_lane_scheduler
//
// Purpose:
//   Directed bench for vector_lane_scheduler. Two instances: a V=20 one with
//   adder lane ALUs and a V=6 one with subtractor lane ALUs (partial last
//   chunk). Expected completions are queued when an operation is issued and
//   a monitor per instance pops and compares on every done_o pulse.
//
// Ports: none.
module tb_vector_lane_scheduler;

  localparam int L = 8;
  localparam int LANES = 4;

  typedef struct {
    string        name;
    logic [159:0] result;
    int           done_cyc;
  } exp_t;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  int           cyc = 0;
  int           n_checks = 0;
  int           n_errors = 0;
  exp_t         q20[$];
  exp_t         q6[$];

  logic         st20 = 1'b0, fl20 = 1'b0;
  logic [1:0]   op20 = 2'b00;
  logic [159:0] a20 = '0, b20 = '0;
  logic [7:0]   sc20 = '0;
  logic [31:0]  la20, lb20, res20;
  logic [3:0]   lv20;
  logic [2:0]   ch20;
  logic [159:0] r20;
  logic         busy20, done20;

  logic         st6 = 1'b0, fl6 = 1'b0;
  logic [1:0]   op6 = 2'b00;
  logic [47:0]  a6 = '0, b6 = '0;
  logic [7:0]   sc6 = '0;
  logic [31:0]  la6, lb6, res6;
  logic [3:0]   lv6;
  logic [0:0]   ch6;
  logic [47:0]  r6;
  logic         busy6, done6;

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  vector_lane_scheduler #(.L(8), .V(20), .LANES(4)) u_dut20 (
    .CLK(CLK), .RST(RST), .start_i(st20), .flush_i(fl20), .op_type_i(op20),
    .vec_a_i(a20), .vec_b_i(b20), .scalar_i(sc20),
    .lane_a_o(la20), .lane_b_o(lb20), .lane_valid_o(lv20),
    .lane_result_i(res20), .chunk_o(ch20), .result_o(r20),
    .busy_o(busy20), .done_o(done20)
  );

  vector_lane_scheduler #(.L(8), .V(6), .LANES(4)) u_dut6 (
    .CLK(CLK), .RST(RST), .start_i(st6), .flush_i(fl6), .op_type_i(op6),
    .vec_a_i(a6), .vec_b_i(b6), .scalar_i(sc6),
    .lane_a_o(la6), .lane_b_o(lb6), .lane_valid_o(lv6),
    .lane_result_i(res6), .chunk_o(ch6), .result_o(r6),
    .busy_o(busy6), .done_o(done6)
  );

  // Lane ALUs: adders on the V=20 instance, subtractors on the V=6 one.
  always_comb begin
    res20 = '0;
    res6  = '0;
    for (int j = 0; j < LANES; j++) begin
      res20[j*L +: L] = la20[j*L +: L] + lb20[j*L +: L];
      res6[j*L +: L]  = la6[j*L +: L] - lb6[j*L +: L];
    end
  end

  function automatic logic [159:0] mk(input int mul, input int add);
    logic [159:0] v;
    v = '0;
    for (int i = 0; i < 20; i++) v[i*8 +: 8] = 8'(mul * i + add);
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [159:0] actual,
                             input logic [159:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Drives one request, waits for the accepting edge and optionally queues
  // the expected completion (result and the cycle done_o should appear in).
  task automatic applyStimulus(input bit sel6, input logic [1:0] op,
                               input logic [159:0] a, input logic [159:0] b,
                               input logic [7:0] sc, input bit push,
                               input string name, input logic [159:0] exp_res,
                               input int latency, input bit hold,
                               output int acc);
    exp_t ent;
    @(negedge CLK);
    if (sel6) begin
      st6 = 1'b1; op6 = op; a6 = a[47:0]; b6 = b[47:0]; sc6 = sc;
    end else begin
      st20 = 1'b1; op20 = op; a20 = a; b20 = b; sc20 = sc;
    end
    @(posedge CLK);
    #1;
    acc = cyc;
    if (push) begin
      ent.name     = name;
      ent.done_cyc = acc + latency;
      if (sel6) begin
        ent.result = {112'd0, exp_res[47:0]};
        q6.push_back(ent);
      end else begin
        ent.result = exp_res;
        q20.push_back(ent);
      end
    end
    if (!hold) begin
      if (sel6) st6 = 1'b0;
      else      st20 = 1'b0;
    end
  endtask

  // Monitors: every done pulse must match the next queued expectation.
  always @(negedge CLK) begin
    exp_t e;
    if (!RST && done20) begin
      if (q20.size() == 0) begin
        checkOutput("dut20_spurious_done", {159'd0, done20}, 160'd0);
      end else begin
        e = q20.pop_front();
        checkOutput({e.name, "_result"}, r20, e.result);
        checkOutput({e.name, "_done_cycle"}, cyc, e.done_cyc);
      end
    end
  end

  always @(negedge CLK) begin
    exp_t e;
    if (!RST && done6) begin
      if (q6.size() == 0) begin
        checkOutput("dut6_spurious_done", {159'd0, done6}, 160'd0);
      end else begin
        e = q6.pop_front();
        checkOutput({e.name, "_result"}, {112'd0, r6}, e.result);
        checkOutput({e.name, "_done_cycle"}, cyc, e.done_cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d errors so far", n_errors);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int           acc;
    int           busy_cnt;
    logic [159:0] exp_flush;

    // Reset state.
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    checkOutput("rst_result", r20, '0);
    checkOutput("rst_busy", busy20, 0);
    checkOutput("rst_done", done20, 0);
    checkOutput("rst_valid", lv20, 0);
    checkOutput("rst_chunk", ch20, 0);
    checkOutput("rst_lane_a", la20, 0);
    checkOutput("rst_dut6_result", r6, 0);

    // Vector-vector add, A[i]=i, B[i]=2i -> 3i.
    $display("[TB] vector-vector add");
    applyStimulus(1'b0, 2'b01, mk(1, 0), mk(2, 0), 8'd0, 1'b1, "vv_add",
                  mk(3, 0), 5, 1'b0, acc);
    busy_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      if (busy20) busy_cnt++;
      if (c < 5) begin
        checkOutput($sformatf("vv_valid_c%0d", c), lv20, 4'hf);
        checkOutput($sformatf("vv_chunk_c%0d", c), ch20, c);
      end
      if (c == 0) checkOutput("vv_lane_a_c0", la20, 32'h03020100);
      if (c == 1) checkOutput("vv_lane_b_c1", lb20, 32'h0e0c0a08);
    end
    checkOutput("vv_busy_cycles", busy_cnt, 6);

    // Vector-scalar subtract on V=6: A[i]=10+i, scalar 5 -> 5+i.
    $display("[TB] vector-scalar subtract, partial chunk");
    applyStimulus(1'b1, 2'b10, mk(1, 10), mk(0, 8'h77), 8'd5, 1'b1, "vs_sub",
                  mk(1, 5), 2, 1'b0, acc);
    @(negedge CLK);
    checkOutput("vs_valid_c0", lv6, 4'hf);
    checkOutput("vs_lane_b_c0", lb6, 32'h05050505);
    @(negedge CLK);
    checkOutput("vs_valid_c1", lv6, 4'b0011);
    checkOutput("vs_chunk_c1", ch6, 1);
    checkOutput("vs_lane_a_c1", la6, 32'h00000f0e);
    checkOutput("vs_lane_b_c1", lb6, 32'h00000505);
    @(negedge CLK);
    @(negedge CLK);
    checkOutput("vs_idle_busy", busy6, 0);

    // Scalar ops: done next cycle, lanes quiet, result untouched.
    $display("[TB] scalar ops");
    applyStimulus(1'b0, 2'b00, mk(5, 1), mk(7, 2), 8'd9, 1'b1, "scalar00",
                  mk(3, 0), 0, 1'b0, acc);
    @(negedge CLK);
    checkOutput("scalar00_valid", lv20, 0);
    checkOutput("scalar00_busy", busy20, 1);
    checkOutput("scalar00_lane_a", la20, 0);
    @(negedge CLK);
    checkOutput("scalar00_idle", busy20, 0);
    applyStimulus(1'b0, 2'b11, mk(2, 3), mk(4, 1), 8'd1, 1'b1, "scalar11",
                  mk(3, 0), 0, 1'b0, acc);
    @(negedge CLK);
    checkOutput("scalar11_valid", lv20, 0);
    @(negedge CLK);

    // Flush during chunk 2: elements 0..11 become i+100, 12..19 keep 3i.
    $display("[TB] flush mid-run");
    applyStimulus(1'b0, 2'b01, mk(1, 0), mk(0, 100), 8'd0, 1'b0, "flush",
                  '0, 0, 1'b0, acc);
    @(negedge CLK);
    @(negedge CLK);
    @(negedge CLK);
    checkOutput("flush_chunk2", ch20, 2);
    fl20 = 1'b1;
    @(posedge CLK);
    #1;
    fl20 = 1'b0;
    @(negedge CLK);
    checkOutput("flush_busy", busy20, 0);
    for (int i = 0; i < 20; i++) exp_flush[i*8 +: 8] = (i < 12) ? 8'(i + 100) : 8'(3 * i);
    checkOutput("flush_result", r20, exp_flush);
    st20 = 1'b1;
    fl20 = 1'b1;
    op20 = 2'b01;
    @(posedge CLK);
    #1;
    st20 = 1'b0;
    fl20 = 1'b0;
    @(negedge CLK);
    checkOutput("start_flush_busy", busy20, 0);
    checkOutput("start_flush_valid", lv20, 0);
    repeat (7) @(negedge CLK);
    checkOutput("start_flush_result", r20, exp_flush);

    // Start held through DONE: second op accepted 7 cycles after the first.
    $display("[TB] back-to-back with start held");
    applyStimulus(1'b0, 2'b01, mk(1, 0), mk(1, 0), 8'd0, 1'b1, "b2b_first",
                  mk(2, 0), 5, 1'b1, acc);
    @(negedge CLK);
    b20 = mk(3, 0);
    q20.push_back('{name: "b2b_second", result: mk(4, 0), done_cyc: acc + 12});
    repeat (7) @(posedge CLK);
    @(negedge CLK);
    st20 = 1'b0;
    repeat (8) @(negedge CLK);

    // Reset asserted mid-run clears every output before the next edge.
    $display("[TB] reset mid-run");
    applyStimulus(1'b0, 2'b01, mk(1, 1), mk(1, 1), 8'd0, 1'b0, "rst_run",
                  '0, 0, 1'b0, acc);
    @(posedge CLK);
    #2;
    RST = 1'b1;
    #1;
    checkOutput("midrst_result", r20, '0);
    checkOutput("midrst_busy", busy20, 0);
    checkOutput("midrst_valid", lv20, 0);
    checkOutput("midrst_lane_a", la20, 0);
    checkOutput("midrst_lane_b", lb20, 0);
    checkOutput("midrst_chunk", ch20, 0);
    checkOutput("midrst_done", done20, 0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    checkOutput("postrst_busy", busy20, 0);
    checkOutput("postrst_valid", lv20, 0);

    repeat (3) @(negedge CLK);
    checkOutput("q20_drained", q20.size(), 0);
    checkOutput("q6_drained", q6.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
